// File: rtl/adc_conv_ctrl_pkg.sv
// Shared definitions for the single-slope ADC conversion sequencer:
// default parameter values and the FSM state encodings.
package adc_conv_ctrl_pkg;

    localparam int unsigned CNT_W_DEF       = 6;
    localparam int unsigned STRB_DIV_DEF    = 4;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    // FSM state encodings, kept as plain constants for compatibility with legacy users
    localparam int unsigned ST_W        = 3;
    localparam logic [2:0]  ST_IDLE     = 3'd0;
    localparam logic [2:0]  ST_CLEAR    = 3'd1;
    localparam logic [2:0]  ST_RAMP     = 3'd2;
    localparam logic [2:0]  ST_CAPT     = 3'd3;
    localparam logic [2:0]  ST_WAIT_ACK = 3'd4;

endpackage

// File: rtl/adc_conv_ctrl_strb_gen.sv
// Free-running strobe generator for the counter stage.
// Ports:
//   clk    system clock
//   rst_l  asynchronous active-low reset
//   strb   registered one-clk pulse, once every STRB_DIV clks
module adc_conv_ctrl_strb_gen
#(
    parameter int unsigned STRB_DIV = 4
) (
    input  logic clk,
    input  logic rst_l,
    output logic strb
);

    localparam int unsigned        DIV_W    = $clog2(STRB_DIV);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(STRB_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic             div_wrap;

    assign div_wrap = (div_q == DIV_LAST);

    // Divider runs in every state, including IDLE; strb marks the wrap
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            div_q <= '0;
            strb  <= 1'b0;
        end else begin
            div_q <= div_wrap ? '0 : div_q + DIV_W'(1);
            strb  <= div_wrap;
        end
    end

endmodule

// File: rtl/adc_conv_ctrl.sv
// Conversion sequencer for the single-slope ADC. Drives the strobed counter
// stage (strb/cnt_rst/cnt_en), controls ramp discharge, synchronises the
// comparator and presents the captured count through a valid/ready port.
// Ports:
//   clk, rst_l          clock, asynchronous active-low reset
//   start               one-cycle request, honoured only in IDLE
//   cmp                 async comparator, 1 = ramp still below Vin
//   cnt                 current counter stage value
//   strb                counter update strobe (registered)
//   cnt_rst, cnt_en     counter clear / increment, qualified by strb (decoded)
//   ramp_rst            1 = hold ramp discharged (decoded)
//   busy                1 whenever not IDLE (decoded)
//   res_data, res_ovf   captured result and saturation flag (registered)
//   res_valid/res_ready result handshake
module adc_conv_ctrl
    import adc_conv_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned STRB_DIV    = STRB_DIV_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             start,
    input  logic             cmp,
    input  logic [CNT_W-1:0] cnt,
    output logic             strb,
    output logic             cnt_rst,
    output logic             cnt_en,
    output logic             ramp_rst,
    output logic             busy,
    output logic [CNT_W-1:0] res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   cmp_s;
    logic [ST_W-1:0]        state_q;
    logic [ST_W-1:0]        state_nxt;
    logic                   ovf_q;
    logic                   cnt_at_max;
    logic                   ramp_done;

    adc_conv_ctrl_strb_gen #(
        .STRB_DIV (STRB_DIV)
    ) u_strb_gen (
        .clk   (clk),
        .rst_l (rst_l),
        .strb  (strb)
    );

    // Comparator synchroniser
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], cmp};
        end
    end

    assign cmp_s      = sync_q[SYNC_STAGES-1];
    assign cnt_at_max = (cnt == CNT_MAX);
    // Ramp ends at a strobe once the comparator tripped or the counter saturated
    assign ramp_done  = strb & (~cmp_s | cnt_at_max);

    // State register
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:     if (start)                  state_nxt = ST_CLEAR;
            ST_CLEAR:    if (strb)                   state_nxt = ST_RAMP;
            ST_RAMP:     if (ramp_done)              state_nxt = ST_CAPT;
            ST_CAPT:                                 state_nxt = ST_WAIT_ACK;
            ST_WAIT_ACK: if (res_valid && res_ready) state_nxt = ST_IDLE;
            default:                                 state_nxt = ST_IDLE;
        endcase
    end

    // Control decodes; counter enable is forced low at MAX so it never wraps
    always_comb begin
        cnt_rst  = 1'b0;
        cnt_en   = 1'b0;
        ramp_rst = 1'b1;
        busy     = (state_q != ST_IDLE);
        case (state_q)
            ST_CLEAR: cnt_rst = 1'b1;
            ST_RAMP: begin
                ramp_rst = 1'b0;
                cnt_en   = cmp_s & ~cnt_at_max;
            end
            default: ;
        endcase
    end

    // Overflow flag and result register; cnt is frozen by the time of CAPT
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            ovf_q     <= 1'b0;
            res_data  <= '0;
            res_valid <= 1'b0;
            res_ovf   <= 1'b0;
        end else begin
            if (state_q == ST_RAMP && ramp_done) begin
                ovf_q <= cmp_s & cnt_at_max;
            end
            if (state_q == ST_CAPT) begin
                res_data  <= cnt;
                res_ovf   <= ovf_q;
                res_valid <= 1'b1;
            end else if (state_q == ST_WAIT_ACK && res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_conv_ctrl.sv
// Bench for adc_conv_ctrl: models the strobed 6-bit counter stage and an
// idealised comparator, and scores results against a reference model.
module tb_adc_conv_ctrl;

    localparam int unsigned CNT_W       = 6;
    localparam int unsigned STRB_DIV    = 4;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int          MAXC        = 63;

    logic             clk;
    logic             rst_l;
    logic             start;
    logic             cmp;
    logic [CNT_W-1:0] cnt;
    logic             strb;
    logic             cnt_rst;
    logic             cnt_en;
    logic             ramp_rst;
    logic             busy;
    logic [CNT_W-1:0] res_data;
    logic             res_valid;
    logic             res_ready;
    logic             res_ovf;

    typedef struct {
        int data;
        int ovf;
        int strobes;
    } exp_t;

    exp_t expq[$];
    int   code;
    int   checks;
    int   failures;
    int   cyc;
    int   ready_mode;

    adc_conv_ctrl #(
        .CNT_W       (CNT_W),
        .STRB_DIV    (STRB_DIV),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .start     (start),
        .cmp       (cmp),
        .cnt       (cnt),
        .strb      (strb),
        .cnt_rst   (cnt_rst),
        .cnt_en    (cnt_en),
        .ramp_rst  (ramp_rst),
        .busy      (busy),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_ovf   (res_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Counter stage: clears or increments only on strb
    always @(posedge clk or negedge rst_l) begin
        if (!rst_l)      cnt <= '0;
        else if (strb) begin
            if (cnt_rst)     cnt <= '0;
            else if (cnt_en) cnt <= cnt + 6'd1;
        end
    end

    // Comparator: a discharged ramp sits at 0, otherwise the ramp tracks cnt
    always_comb begin
        if (ramp_rst) cmp = (code > 0);
        else          cmp = (int'(cnt) < code);
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected outcome from the conversion rules alone
    function automatic exp_t ref_model(input int c);
        exp_t e;
        if (c > MAXC) begin
            e.data = MAXC; e.ovf = 1; e.strobes = MAXC + 1;
        end else begin
            e.data = c;    e.ovf = 0; e.strobes = c + 1;
        end
        return e;
    endfunction

    task automatic check_reset_vals();
        check("rst_strb",      int'(strb),      0);
        check("rst_cnt_rst",   int'(cnt_rst),   0);
        check("rst_cnt_en",    int'(cnt_en),    0);
        check("rst_ramp_rst",  int'(ramp_rst),  1);
        check("rst_busy",      int'(busy),      0);
        check("rst_res_data",  int'(res_data),  0);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_res_ovf",   int'(res_ovf),   0);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (expq.size() > 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (expq.size() > 0) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d pending required=0 pending", expq.size());
            expq.delete();
        end
    endtask

    task automatic conv(input int c, input bit extra_start);
        code = c;
        expq.push_back(ref_model(c));
        pulse_start();
        if (extra_start) begin
            repeat (2) @(posedge clk);
            pulse_start();
        end
        wait_drain(2000);
    endtask

    // Ready driver
    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       res_ready = 1'b1;
                1:       res_ready = 1'($urandom_range(0, 1));
                default: res_ready = 1'b0;
            endcase
        end
    end

    // Monitor: strobe cadence, no-wrap, result scoreboard and handshake
    initial begin
        int   last_strb;
        int   last_ramp_strb;
        int   ramp_strobes;
        bit   prev_hold;
        int   prev_data;
        bit   pend_clear;
        exp_t e;
        last_strb = -1; last_ramp_strb = -1; ramp_strobes = 0;
        prev_hold = 0; prev_data = 0; pend_clear = 0;
        forever begin
            @(negedge clk);
            if (!rst_l) begin
                last_strb = -1; ramp_strobes = 0; prev_hold = 0; pend_clear = 0;
            end else begin
                if (strb) begin
                    if (last_strb >= 0) check("strb_period", cyc - last_strb, int'(STRB_DIV));
                    last_strb = cyc;
                    if (!ramp_rst) begin
                        ramp_strobes++;
                        last_ramp_strb = cyc;
                    end
                    if (cnt_en) check("cnt_no_wrap", int'(cnt), MAXC - 1 < int'(cnt) ? -1 : int'(cnt));
                end
                if (pend_clear) begin
                    check("ack_valid_clr", int'(res_valid), 0);
                    check("ack_idle",      int'(busy),      0);
                    pend_clear = 0;
                end
                if (res_valid) begin
                    if (!prev_hold) begin
                        if (expq.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_result actual=%0d required=none", res_data);
                        end else begin
                            e = expq[0];
                            check("res_data",     int'(res_data), e.data);
                            check("res_ovf",      int'(res_ovf),  e.ovf);
                            check("ramp_strobes", ramp_strobes,   e.strobes);
                            check("valid_lat",    cyc - last_ramp_strb, 2);
                            check("cnt_frozen",   int'(cnt),      e.data);
                        end
                        ramp_strobes = 0;
                    end else begin
                        check("hold_data", int'(res_data), prev_data);
                        check("hold_busy", int'(busy),     1);
                    end
                    if (res_ready) begin
                        if (expq.size() > 0) void'(expq.pop_front());
                        pend_clear = 1;
                    end
                end
                prev_hold = res_valid && !res_ready;
                prev_data = int'(res_data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        checks = 0; failures = 0; cyc = 0;
        code = 0; start = 1'b0; ready_mode = 0;
        rst_l = 1'b0;
        #23;
        check_reset_vals();
        @(negedge clk);
        rst_l = 1'b1;

        // Idle cadence
        repeat (40) begin
            @(negedge clk);
            check("idle_busy",     int'(busy),     0);
            check("idle_ramp_rst", int'(ramp_rst), 1);
        end

        // Nominal, zero code, overflow and the last non-saturating code
        conv(10, 1'b0);
        conv(0, 1'b0);
        conv(64, 1'b0);
        conv(MAXC, 1'b0);

        // Backpressure with dropped starts
        ready_mode = 2;
        code = 20;
        expq.push_back(ref_model(20));
        pulse_start();
        n = 0;
        while (!res_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", int'(res_valid), 1);
        repeat (5) @(posedge clk);
        pulse_start();
        repeat (5) @(posedge clk);
        pulse_start();
        repeat (8) @(posedge clk);
        ready_mode = 0;
        wait_drain(100);
        conv(33, 1'b0);

        // Randomised conversions with random backpressure and dropped starts
        ready_mode = 1;
        for (int i = 0; i < 15; i++) begin
            conv(int'($urandom_range(0, 70)), 1'($urandom_range(0, 1)));
        end
        ready_mode = 0;

        // Reset mid-ramp
        code = 40;
        pulse_start();
        n = 0;
        while (int'(cnt) != 25 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("reach_cnt25", int'(cnt), 25);
        #2 rst_l = 1'b0;
        #1;
        check_reset_vals();
        repeat (3) @(negedge clk);
        rst_l = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_busy",  int'(busy),      0);
            check("post_rst_valid", int'(res_valid), 0);
        end
        conv(25, 1'b0);

        repeat (10) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
